cordic_host_ctrl: RTL and testbench
===================================

CORDIC_HOST_CTRL -- requirements
Module: cordic_host_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: angle and result width; angle unit is 2^WIDTH = full turn.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before an error response.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  1  request valid.
REQ-006 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-007 req_angle_i  in  WIDTH  unsigned angle, full-turn units.
REQ-008 core_start_o  out  1  one-cycle start pulse to the CORDIC core controller.
REQ-009 core_angle_o  out  WIDTH  first-quadrant residual angle to the core.
REQ-010 core_done_tick_i  in  1  one-cycle completion tick from the core.
REQ-011 core_cos_i, core_sin_i  in  WIDTH each  signed core results.
REQ-012 rsp_valid_o  out  1  response valid.
REQ-013 rsp_ready_i  in  1  response consumed when rsp_valid_o and rsp_ready_i are both high.
REQ-014 rsp_cos_o, rsp_sin_o  out  WIDTH each  signed quadrant-corrected results.
REQ-015 rsp_err_o  out  1  high with rsp_valid_o when the core timed out.
REQ-016 busy_o  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, LAUNCH, WAIT, HOLD.
REQ-018 IDLE: req_ready_o=1; on handshake, latch q=req_angle_i[WIDTH-1:WIDTH-2] and core_angle_o={2'b00, req_angle_i[WIDTH-3:0]}, then go to LAUNCH.
REQ-019 LAUNCH: core_start_o=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
REQ-020 WAIT: on core_done_tick_i, register the corrected results with rsp_err_o=0 and go to HOLD. Otherwise increment the counter; when the counter reaches TIMEOUT-1 without a tick, register results=0 and rsp_err_o=1, then go to HOLD.
REQ-021 HOLD: rsp_valid_o=1 and all rsp_* outputs are held stable; on rsp_ready_i go to IDLE.
REQ-022 Quadrant correction, with c=core_cos_i and s=core_sin_i: q=0 -> (c,s); q=1 -> (-s,c); q=2 -> (-c,-s); q=3 -> (s,-c), given as (cos,sin).
REQ-023 Negation SHALL saturate: -(-2^(WIDTH-1)) = 2^(WIDTH-1)-1. No other overflow is possible.
REQ-024 core_angle_o SHALL stay stable from LAUNCH until the next request is accepted.
REQ-025 core_done_tick_i SHALL be ignored in IDLE, LAUNCH and HOLD; a late tick after a timeout SHALL NOT alter the response.
REQ-026 Latency: accept at cycle 0; core_start_o at cycle 1; tick at cycle N (N>=2); rsp_valid_o at cycle N+1.
REQ-027 req_ready_o SHALL be 0 in LAUNCH, WAIT and HOLD. There is no request queueing.
REQ-028 When rsp_ready_i is already high on entry to HOLD, the handshake SHALL complete in that first HOLD cycle, and req_ready_o SHALL be 1 in the following cycle.
REQ-029 An illegal state encoding SHALL return the FSM to IDLE.

Reset
REQ-030 Reset SHALL force state=IDLE, counter=0, q=0, core_angle_o=0, rsp_cos_o=0, rsp_sin_o=0, rsp_err_o=0, core_start_o=0, rsp_valid_o=0, busy_o=0.
REQ-031 Reset asserted in any state SHALL abort the transaction; no response is produced for it.

Structure
REQ-032 Package cordic_pkg SHALL hold CORDIC_WIDTH, the host-state enum typedef, the 2-bit quadrant typedef and the quadrant encodings.
REQ-033 Quadrant correction and saturating negation SHALL live in the combinational sub-module cordic_quadrant_fix, instantiated once.
REQ-034 All outputs SHALL be registered, except req_ready_o, busy_o and core_start_o, which are decoded from state.

Verification
REQ-035 Angle 0x2000 (45 deg), core returns c=s=0x5A82 after 18 cycles -> rsp_cos=0x5A82, rsp_sin=0x5A82, err=0, rsp_valid exactly one cycle after the tick.
REQ-036 Angle 0x6000 (q=1), core c=0x5A82, s=0x2000 -> rsp_cos=0xE000, rsp_sin=0x5A82; core_angle_o=0x2000.
REQ-037 Angle 0x8000 (q=2), core c=0x8000, s=0 -> rsp_cos=0x7FFF (saturated), rsp_sin=0x0000.
REQ-038 No tick for 64 WAIT cycles -> rsp_err=1, results 0; a tick 5 cycles later is ignored and HOLD data is unchanged.
REQ-039 rsp_ready_i held low for 10 cycles with req_valid_i high -> req_ready_o stays 0 and rsp_* stay stable; then back-to-back requests complete in order.
REQ-040 rst_i pulsed in WAIT -> all outputs are 0 immediately, and the next request gives a correct response with no stale data.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC host-side controller and its
// quadrant-correction stage.
package cordic_pkg;

    localparam int CORDIC_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } host_state_t;

    typedef logic [1:0] quad_t;

    localparam quad_t QUAD_0 = 2'd0;
    localparam quad_t QUAD_1 = 2'd1;
    localparam quad_t QUAD_2 = 2'd2;
    localparam quad_t QUAD_3 = 2'd3;

endpackage

// File: rtl/cordic_quadrant_fix.sv
// Maps first-quadrant core results back to the requested quadrant by a
// rotation of q * 90 degrees, with saturating negation.
module cordic_quadrant_fix
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH
) (
    input  quad_t            quad,
    input  logic [WIDTH-1:0] cos_in,
    input  logic [WIDTH-1:0] sin_in,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out
);

    // The most negative value has no positive twin, so it clamps to max.
    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] x);
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
        return -x;
    endfunction

    always_comb begin
        cos_out = cos_in;
        sin_out = sin_in;
        case (quad)
            QUAD_0: begin
                cos_out = cos_in;
                sin_out = sin_in;
            end
            QUAD_1: begin
                cos_out = sat_neg(sin_in);
                sin_out = cos_in;
            end
            QUAD_2: begin
                cos_out = sat_neg(cos_in);
                sin_out = sat_neg(sin_in);
            end
            QUAD_3: begin
                cos_out = sin_in;
                sin_out = sat_neg(cos_in);
            end
            default: begin
                cos_out = cos_in;
                sin_out = sin_in;
            end
        endcase
    end

endmodule

// File: rtl/cordic_host_ctrl.sv
// Host-side request/response wrapper around a first-quadrant CORDIC core:
// reduces the angle, launches the core, corrects the result, guards with a timeout.
module cordic_host_ctrl
    import cordic_pkg::*;
#(
    parameter int WIDTH   = CORDIC_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_angle_i,
    output logic             core_start_o,
    output logic [WIDTH-1:0] core_angle_o,
    input  logic             core_done_tick_i,
    input  logic [WIDTH-1:0] core_cos_i,
    input  logic [WIDTH-1:0] core_sin_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_cos_o,
    output logic [WIDTH-1:0] rsp_sin_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    host_state_t      state;
    quad_t            quad;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] fix_cos;
    logic [WIDTH-1:0] fix_sin;

    assign req_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign core_start_o = (state == LAUNCH);

    cordic_quadrant_fix #(
        .WIDTH (WIDTH)
    ) u_quadrant_fix (
        .quad    (quad),
        .cos_in  (core_cos_i),
        .sin_in  (core_sin_i),
        .cos_out (fix_cos),
        .sin_out (fix_sin)
    );

    // Response registers only change on the WAIT exit, so HOLD data is immune to late ticks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            count        <= '0;
            quad         <= QUAD_0;
            core_angle_o <= '0;
            rsp_cos_o    <= '0;
            rsp_sin_o    <= '0;
            rsp_err_o    <= 1'b0;
            rsp_valid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        quad         <= quad_t'(req_angle_i[WIDTH-1:WIDTH-2]);
                        core_angle_o <= {2'b00, req_angle_i[WIDTH-3:0]};
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done_tick_i) begin
                        rsp_cos_o   <= fix_cos;
                        rsp_sin_o   <= fix_sin;
                        rsp_err_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= HOLD;
                    end else if (count == CNT_W'(TIMEOUT - 1)) begin
                        rsp_cos_o   <= '0;
                        rsp_sin_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_valid_o <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_host_ctrl.sv
// Directed bench for cordic_host_ctrl: the bench plays the CORDIC core and
// checks hand-computed responses, timeout, back-pressure and reset abort.
module tb_cordic_host_ctrl;
    import cordic_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_angle;
    logic         core_start;
    logic [W-1:0] core_angle;
    logic         core_done;
    logic [W-1:0] core_cos;
    logic [W-1:0] core_sin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_cos;
    logic [W-1:0] rsp_sin;
    logic         rsp_err;
    logic         busy;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    cordic_host_ctrl #(
        .WIDTH   (W),
        .TIMEOUT (64)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_angle_i      (req_angle),
        .core_start_o     (core_start),
        .core_angle_o     (core_angle),
        .core_done_tick_i (core_done),
        .core_cos_i       (core_cos),
        .core_sin_i       (core_sin),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_cos_o        (rsp_cos),
        .rsp_sin_o        (rsp_sin),
        .rsp_err_o        (rsp_err),
        .busy_o           (busy)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count += 1;
        assert (obs === exp) pass_count += 1;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance n clock edges, landing 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Handshake one request from IDLE; returns in the LAUNCH cycle.
    task automatic apply_stimulus(input logic [W-1:0] angle);
        req_valid = 1'b1;
        req_angle = angle;
        step(1);
        req_valid = 1'b0;
    endtask

    // From LAUNCH: enter WAIT, idle extra cycles, pulse the done tick; returns in the first HOLD cycle.
    task automatic core_reply(input int extra, input logic [W-1:0] c, input logic [W-1:0] s);
        step(1);
        step(extra);
        core_done = 1'b1;
        core_cos  = c;
        core_sin  = s;
        step(1);
        core_done = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [W-1:0] c, input logic [W-1:0] s, input logic e);
        check_output({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_output({tag, "_cos"}, {16'd0, rsp_cos}, {16'd0, c});
        check_output({tag, "_sin"}, {16'd0, rsp_sin}, {16'd0, s});
        check_output({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e});
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_angle = '0;
        core_done = 1'b0;
        core_cos  = '0;
        core_sin  = '0;
        rsp_ready = 1'b0;
        step(2);

        $display("[TB] reset state");
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("rst_start", {31'd0, core_start}, 32'd0);
        check_output("rst_angle", {16'd0, core_angle}, 32'd0);
        check_output("rst_cos", {16'd0, rsp_cos}, 32'd0);
        check_output("rst_err", {31'd0, rsp_err}, 32'd0);
        check_output("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        step(1);

        $display("[TB] 45 degrees, tick at cycle 18");
        apply_stimulus(16'h2000);
        check_output("t1_start", {31'd0, core_start}, 32'd1);
        check_output("t1_angle", {16'd0, core_angle}, 32'h2000);
        check_output("t1_ready_launch", {31'd0, req_ready}, 32'd0);
        check_output("t1_busy", {31'd0, busy}, 32'd1);
        step(1);
        check_output("t1_start_pulse", {31'd0, core_start}, 32'd0);
        step(16);
        check_output("t1_valid_early", {31'd0, rsp_valid}, 32'd0);
        core_done = 1'b1;
        core_cos  = 16'h5A82;
        core_sin  = 16'h5A82;
        step(1);
        core_done = 1'b0;
        check_rsp("t1", 16'h5A82, 16'h5A82, 1'b0);
        release_rsp();
        check_output("t1_idle_ready", {31'd0, req_ready}, 32'd1);
        check_output("t1_idle_valid", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] quadrant 1");
        apply_stimulus(16'h6000);
        check_output("t2_angle", {16'd0, core_angle}, 32'h2000);
        core_reply(3, 16'h5A82, 16'h2000);
        check_rsp("t2", 16'hE000, 16'h5A82, 1'b0);
        check_output("t2_angle_hold", {16'd0, core_angle}, 32'h2000);
        release_rsp();

        $display("[TB] quadrant 2 with saturation");
        apply_stimulus(16'h8000);
        check_output("t3_angle", {16'd0, core_angle}, 32'h0000);
        core_reply(1, 16'h8000, 16'h0000);
        check_rsp("t3", 16'h7FFF, 16'h0000, 1'b0);
        release_rsp();

        $display("[TB] quadrant 3 with saturation");
        apply_stimulus(16'hD000);
        check_output("t4_angle", {16'd0, core_angle}, 32'h1000);
        core_reply(0, 16'h1000, 16'h8000);
        check_rsp("t4", 16'h8000, 16'hF000, 1'b0);
        release_rsp();

        $display("[TB] timeout then late tick");
        apply_stimulus(16'h4000);
        core_cos = 16'h1234;
        core_sin = 16'h4321;
        step(1);
        step(63);
        check_output("t5_valid_before_to", {31'd0, rsp_valid}, 32'd0);
        check_output("t5_busy_wait", {31'd0, busy}, 32'd1);
        step(1);
        check_rsp("t5", 16'h0000, 16'h0000, 1'b1);
        step(4);
        core_done = 1'b1;
        core_cos  = 16'h7777;
        core_sin  = 16'h6666;
        step(1);
        core_done = 1'b0;
        check_rsp("t5_late", 16'h0000, 16'h0000, 1'b1);
        release_rsp();

        $display("[TB] back-pressure and back-to-back");
        apply_stimulus(16'h2000);
        core_reply(2, 16'h1000, 16'h2000);
        req_valid = 1'b1;
        req_angle = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_output("t6_ready_stall", {31'd0, req_ready}, 32'd0);
            check_rsp("t6_stall", 16'h1000, 16'h2000, 1'b0);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check_output("t6_ready_after", {31'd0, req_ready}, 32'd1);
        check_output("t6_valid_after", {31'd0, rsp_valid}, 32'd0);
        step(1);
        req_valid = 1'b0;
        check_output("t6_second_start", {31'd0, core_start}, 32'd1);
        check_output("t6_second_angle", {16'd0, core_angle}, 32'h0000);
        core_reply(1, 16'h7FFF, 16'h0123);
        check_rsp("t6_second", 16'hFEDD, 16'h7FFF, 1'b0);
        release_rsp();

        $display("[TB] response ready already high on HOLD entry");
        apply_stimulus(16'hA000);
        check_output("t7_angle", {16'd0, core_angle}, 32'h2000);
        rsp_ready = 1'b1;
        core_reply(0, 16'h0100, 16'h8000);
        check_rsp("t7", 16'hFF00, 16'h7FFF, 1'b0);
        step(1);
        rsp_ready = 1'b0;
        check_output("t7_ready_next", {31'd0, req_ready}, 32'd1);
        check_output("t7_valid_next", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] reset during WAIT");
        apply_stimulus(16'h6000);
        step(4);
        #1;
        rst = 1'b1;
        #1;
        check_output("t8_busy", {31'd0, busy}, 32'd0);
        check_output("t8_start", {31'd0, core_start}, 32'd0);
        check_output("t8_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("t8_err", {31'd0, rsp_err}, 32'd0);
        check_output("t8_cos", {16'd0, rsp_cos}, 32'd0);
        check_output("t8_sin", {16'd0, rsp_sin}, 32'd0);
        check_output("t8_angle", {16'd0, core_angle}, 32'd0);
        step(1);
        rst = 1'b0;
        step(3);
        check_output("t8_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check_output("t8_idle", {31'd0, req_ready}, 32'd1);
        apply_stimulus(16'h2000);
        check_output("t8_new_angle", {16'd0, core_angle}, 32'h2000);
        core_reply(2, 16'h1111, 16'h2222);
        check_rsp("t8_new", 16'h1111, 16'h2222, 1'b0);
        release_rsp();

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
